// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared constants, state type and S-box helpers for the PRESENT key schedule
package present_pkg;

    localparam int RK_W       = 64;
    localparam int NUM_RK_DEF = 32;
    localparam int KEY_W_80   = 80;
    localparam int KEY_W_128  = 128;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        EMIT
    } state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/present_ks_step.sv
// rtl/present_ks_step.sv - combinational single-step key update, forward or inverse (PRESENT_KS_DECRYPT_EN)
module present_ks_step
    import present_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic [KEY_W-1:0] key_i,
    input  logic [4:0]       ctr_i,
    input  logic             inv_i,
    output logic [KEY_W-1:0] key_o
);

    localparam int XOR_LSB = (KEY_W == KEY_W_128) ? 62 : 15;

    logic [KEY_W-1:0] rot;
    logic [KEY_W-1:0] fwd;

    always_comb begin
        rot = {key_i[KEY_W-62:0], key_i[KEY_W-1:KEY_W-61]};
        fwd = rot;
        fwd[KEY_W-1 -: 4] = sbox4(rot[KEY_W-1 -: 4]);
        if (KEY_W == KEY_W_128) begin
            fwd[KEY_W-5 -: 4] = sbox4(rot[KEY_W-5 -: 4]);
        end
        fwd[XOR_LSB +: 5] = fwd[XOR_LSB +: 5] ^ ctr_i;
    end

`ifdef PRESENT_KS_DECRYPT_EN
    logic [KEY_W-1:0] unx;
    logic [KEY_W-1:0] inv;

    // Undo the forward steps in the opposite order: counter, S-box, rotation.
    always_comb begin
        unx = key_i;
        unx[XOR_LSB +: 5] = unx[XOR_LSB +: 5] ^ ctr_i;
        unx[KEY_W-1 -: 4] = inv_sbox4(unx[KEY_W-1 -: 4]);
        if (KEY_W == KEY_W_128) begin
            unx[KEY_W-5 -: 4] = inv_sbox4(unx[KEY_W-5 -: 4]);
        end
        inv = {unx[60:0], unx[KEY_W-1:61]};
    end

    assign key_o = inv_i ? inv : fwd;
`else
    logic unused_inv;
    assign unused_inv = inv_i;
    assign key_o      = fwd;
`endif

endmodule

// File: rtl/present_key_sched_stream.sv
// rtl/present_key_sched_stream.sv - streaming PRESENT-80/128 round-key generator; reverse order with PRESENT_KS_DECRYPT_EN
module present_key_sched_stream
    import present_pkg::*;
#(
    parameter int KEY_W  = 80,
    parameter int NUM_RK = NUM_RK_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           decrypt,
    input  logic [KEY_W-1:0]               key_in,
    output logic                           rk_valid,
    input  logic                           rk_ready,
    output logic [RK_W-1:0]                round_key,
    output logic [$clog2(NUM_RK+1)-1:0]    rk_index,
    output logic                           busy,
    output logic                           done
);

    // Index is wide enough to hold NUM_RK itself, since indices are 1-based.
    localparam int IDX_W = $clog2(NUM_RK + 1);
    localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_RK);
    localparam logic [IDX_W-1:0] IDX_PREP_END = IDX_W'(NUM_RK - 1);

    if (KEY_W != KEY_W_80 && KEY_W != KEY_W_128) begin : g_bad_key_w
        $error("present_key_sched_stream: KEY_W must be 80 or 128");
    end

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [KEY_W-1:0]   step_key;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               dec_q, dec_d;
    logic               done_q, done_d;
    logic               start_dec;
    logic               step_inv;
    logic               emit_last;
    logic [4:0]         step_ctr;

`ifdef PRESENT_KS_DECRYPT_EN
    assign start_dec = decrypt;
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
    assign start_dec      = 1'b0;
`endif

    // Stepping back from key i undoes the forward step that used counter i-1.
    assign step_inv  = (state_q == EMIT) && dec_q;
    assign step_ctr  = idx_q[4:0] - {4'd0, step_inv};
    assign emit_last = dec_q ? (idx_q == IDX_ONE) : (idx_q == IDX_LAST);

    present_ks_step #(
        .KEY_W(KEY_W)
    ) u_step (
        .key_i(key_q),
        .ctr_i(step_ctr),
        .inv_i(step_inv),
        .key_o(step_key)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    idx_d   = IDX_ONE;
                    dec_d   = start_dec;
                    state_d = start_dec ? PREP : EMIT;
                end
            end
`ifdef PRESENT_KS_DECRYPT_EN
            PREP: begin
                key_d = step_key;
                idx_d = idx_q + IDX_ONE;
                if (idx_q == IDX_PREP_END) begin
                    state_d = EMIT;
                end
            end
`endif
            EMIT: begin
                if (rk_ready) begin
                    if (emit_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = step_key;
                        idx_d = dec_q ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid  = (state_q == EMIT);
    assign round_key = rk_valid ? key_q[KEY_W-1 -: RK_W] : '0;
    assign rk_index  = rk_valid ? idx_q : '0;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
